// File: rtl/stretch_pkg.sv
// Shared definitions for the multi-channel pulse stretcher: trigger modes,
// per-channel FSM encoding and counter sizing helpers.
package stretch_pkg;

  localparam int unsigned EDGE_RISE = 0;
  localparam int unsigned EDGE_FALL = 1;
  localparam int unsigned EDGE_BOTH = 2;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_STRETCH = 2'd1,
    ST_HOLDOFF = 2'd2
  } state_e;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  // One counter serves both the stretch and the holdoff phase.
  function automatic int unsigned cnt_width(input int unsigned min_dur,
                                            input int unsigned holdoff);
    return $clog2(max_u(min_dur, holdoff) + 1);
  endfunction

endpackage

// File: rtl/stretch_chan.sv
// One pulse-stretcher channel: input synchroniser, edge detect, stretch/holdoff
// FSM with shared down-counter, and a sticky overrun flag.
module stretch_chan
  import stretch_pkg::*;
#(
  parameter int unsigned MIN_DURATION = 5,
  parameter int unsigned HOLDOFF      = 0,
  parameter int unsigned EDGE         = 0,
  parameter int unsigned RETRIGGER    = 1,
  parameter int unsigned PASSTHRU     = 1
) (
  input  logic clk_i,
  input  logic reset_ni,
  input  logic armed_i,
  input  logic in_i,
  input  logic clr_i,
  output logic out_o,
  output logic busy_o,
  output logic overrun_o
);

  localparam int unsigned CW = cnt_width(MIN_DURATION, HOLDOFF);
  localparam logic [CW-1:0] LOAD_STRETCH = CW'(MIN_DURATION - 1);
  localparam logic [CW-1:0] LOAD_HOLD    = CW'((HOLDOFF > 0) ? HOLDOFF - 1 : 0);
  localparam logic [CW-1:0] ONE          = CW'(1);
  localparam logic          HOLD_EN      = (HOLDOFF > 0);
  localparam logic          RETRIG_EN    = (RETRIGGER != 0);
  localparam logic          PASS_EN      = (PASSTHRU != 0);

  logic          s1_q, s2_q, s3_q;
  logic          rise, fall, edge_hit, trig, drop;
  logic          ovr_q;
  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= in_i;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  always_comb begin
    rise = s2_q & ~s3_q;
    fall = ~s2_q & s3_q;
    if (EDGE == EDGE_RISE)      edge_hit = rise;
    else if (EDGE == EDGE_FALL) edge_hit = fall;
    else                        edge_hit = rise | fall;
    trig = armed_i & edge_hit;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    drop    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (trig) begin
          state_d = ST_STRETCH;
          cnt_d   = LOAD_STRETCH;
        end
      end
      ST_STRETCH: begin
        // A retrigger reloads even on the final count, keeping the output continuous.
        if (trig && RETRIG_EN) begin
          cnt_d = LOAD_STRETCH;
        end else begin
          drop = trig;
          if (cnt_q == '0) begin
            if (HOLD_EN) begin
              state_d = ST_HOLDOFF;
              cnt_d   = LOAD_HOLD;
            end else begin
              state_d = ST_IDLE;
              cnt_d   = '0;
            end
          end else begin
            cnt_d = cnt_q - ONE;
          end
        end
      end
      ST_HOLDOFF: begin
        drop = trig;
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - ONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (drop)       ovr_q <= 1'b1;
      else if (clr_i) ovr_q <= 1'b0;
    end
  end

  assign out_o     = (state_q == ST_STRETCH) | (PASS_EN & s2_q);
  assign busy_o    = (state_q != ST_IDLE);
  assign overrun_o = ovr_q;

endmodule

// File: rtl/stretch_pulse_mc.sv
// Multi-channel pulse stretcher: independent stretch_chan instances sharing a
// post-reset arm counter that masks edges from inputs static at release.
module stretch_pulse_mc
  import stretch_pkg::*;
#(
  parameter int unsigned CHANNELS     = 4,
  parameter int unsigned SYSTEM_CLOCK = 50000000,
  parameter int unsigned MIN_DURATION = SYSTEM_CLOCK / 10,
  parameter int unsigned HOLDOFF      = 0,
  parameter int unsigned EDGE         = 0,
  parameter int unsigned RETRIGGER    = 1,
  parameter int unsigned PASSTHRU     = 1
) (
  input  logic                clk_i,
  input  logic                reset_ni,
  input  logic [CHANNELS-1:0] in_i,
  input  logic [CHANNELS-1:0] clr_i,
  output logic [CHANNELS-1:0] out_o,
  output logic [CHANNELS-1:0] busy_o,
  output logic [CHANNELS-1:0] overrun_o
);

  logic [1:0] arm_q;
  logic       armed;

  assign armed = &arm_q;

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      arm_q <= '0;
    end else if (!armed) begin
      arm_q <= arm_q + 2'd1;
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
    stretch_chan #(
      .MIN_DURATION (MIN_DURATION),
      .HOLDOFF      (HOLDOFF),
      .EDGE         (EDGE),
      .RETRIGGER    (RETRIGGER),
      .PASSTHRU     (PASSTHRU)
    ) u_chan (
      .clk_i     (clk_i),
      .reset_ni  (reset_ni),
      .armed_i   (armed),
      .in_i      (in_i[g]),
      .clr_i     (clr_i[g]),
      .out_o     (out_o[g]),
      .busy_o    (busy_o[g]),
      .overrun_o (overrun_o[g])
    );
  end

endmodule

// File: tb/tb_stretch_pulse_mc.sv
// Directed bench for stretch_pulse_mc: per-cycle expected traces as bit masks
// (bit i = value after the i-th clock edge of the trace).
module tb_stretch_pulse_mc;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_n;
  logic [1:0] in_a, in_b, in_c, clr_a, clr_b, clr_c;
  logic [1:0] out_a, out_b, out_c, busy_a, busy_b, busy_c, ovr_a, ovr_b, ovr_c;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  // a: rising, retrigger, no passthrough
  stretch_pulse_mc #(
    .CHANNELS(2), .MIN_DURATION(5), .HOLDOFF(3), .EDGE(0), .RETRIGGER(1), .PASSTHRU(0)
  ) dut_a (
    .clk_i(clk), .reset_ni(reset_n), .in_i(in_a), .clr_i(clr_a),
    .out_o(out_a), .busy_o(busy_a), .overrun_o(ovr_a)
  );

  // b: rising, no retrigger, no passthrough
  stretch_pulse_mc #(
    .CHANNELS(2), .MIN_DURATION(5), .HOLDOFF(3), .EDGE(0), .RETRIGGER(0), .PASSTHRU(0)
  ) dut_b (
    .clk_i(clk), .reset_ni(reset_n), .in_i(in_b), .clr_i(clr_b),
    .out_o(out_b), .busy_o(busy_b), .overrun_o(ovr_b)
  );

  // c: both edges, retrigger, passthrough
  stretch_pulse_mc #(
    .CHANNELS(2), .MIN_DURATION(5), .HOLDOFF(3), .EDGE(2), .RETRIGGER(1), .PASSTHRU(1)
  ) dut_c (
    .clk_i(clk), .reset_ni(reset_n), .in_i(in_c), .clr_i(clr_c),
    .out_o(out_c), .busy_o(busy_c), .overrun_o(ovr_c)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_inputs(input int unsigned dut, input logic [1:0] v_in, input logic [1:0] v_clr);
    case (dut)
      0:       begin in_a = v_in; clr_a = v_clr; end
      1:       begin in_b = v_in; clr_b = v_clr; end
      default: begin in_c = v_in; clr_c = v_clr; end
    endcase
  endtask

  task automatic get_outputs(input int unsigned dut, output logic [1:0] o,
                             output logic [1:0] b, output logic [1:0] v);
    case (dut)
      0:       begin o = out_a; b = busy_a; v = ovr_a; end
      1:       begin o = out_b; b = busy_b; v = ovr_b; end
      default: begin o = out_c; b = busy_c; v = ovr_c; end
    endcase
  endtask

  task automatic run_trace(input int unsigned dut, input logic [1:0] chs,
                           input logic [31:0] in_m, input logic [31:0] clr_m,
                           input int unsigned n, input logic [31:0] eo,
                           input logic [31:0] eb, input logic [31:0] ev, input string name);
    logic [1:0] o, b, v;
    for (int unsigned i = 0; i < n; i++) begin
      set_inputs(dut, chs & {2{in_m[i]}}, chs & {2{clr_m[i]}});
      @(posedge clk);
      #1;
      get_outputs(dut, o, b, v);
      for (int unsigned c = 0; c < 2; c++) begin
        if (chs[c]) begin
          check_eq($sformatf("%s t%0d ch%0d out", name, i, c), 32'(o[c]), 32'(eo[i]));
          check_eq($sformatf("%s t%0d ch%0d busy", name, i, c), 32'(b[c]), 32'(eb[i]));
          check_eq($sformatf("%s t%0d ch%0d ovr", name, i, c), 32'(v[c]), 32'(ev[i]));
        end
      end
    end
    set_inputs(dut, 2'b00, 2'b00);
  endtask

  initial begin
    reset_n = 1'b0;
    in_a = '0; in_b = '0; in_c = '0;
    clr_a = '0; clr_b = '0; clr_c = '0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst out", {26'd0, out_a, out_b, out_c}, 32'd0);
    check_eq("rst busy", {26'd0, busy_a, busy_b, busy_c}, 32'd0);
    check_eq("rst ovr", {26'd0, ovr_a, ovr_b, ovr_c}, 32'd0);
    reset_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;

    // single pulse on both channels at once: out 5 clocks, busy 8 clocks
    run_trace(0, 2'b11, 32'h1, 32'h0, 12, 32'h0000_007C, 32'h0000_03FC, 32'h0, "single");
    // second pulse reloads during stretch: out 8 clocks continuous
    run_trace(0, 2'b01, 32'h9, 32'h0, 14, 32'h0000_03FC, 32'h0000_1FFC, 32'h0, "retrig");

    // no retrigger: drops in stretch (edge 5) and holdoff (edge 8) set overrun
    run_trace(1, 2'b01, 32'h49, 32'h0, 12, 32'h0000_007C, 32'h0000_03FC, 32'h0000_0FE0, "drop");
    run_trace(1, 2'b01, 32'h0, 32'h1, 2, 32'h0, 32'h0, 32'h0, "clear");
    run_trace(1, 2'b01, 32'h9, 32'h20, 12, 32'h0000_007C, 32'h0000_03FC, 32'h0000_0FE0, "clr_vs_drop");
    run_trace(1, 2'b01, 32'h0, 32'h1, 2, 32'h0, 32'h0, 32'h0, "clear2");

    // both edges + passthrough, 20-clock input; one-clock gap before the fall stretch
    run_trace(2, 2'b10, 32'h000F_FFFF, 32'h0, 32, 32'h07DF_FFFE, 32'h3FC0_03FC, 32'h0, "both");

    // input high across reset release must not trigger
    set_inputs(0, 2'b01, 2'b00);
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    check_eq("rst_hi out", 32'(out_a), 32'd0);
    check_eq("rst_hi busy", 32'(busy_a), 32'd0);
    reset_n = 1'b1;
    run_trace(0, 2'b01, 32'hFFFF_FFFF, 32'h0, 10, 32'h0, 32'h0, 32'h0, "static_hi");
    run_trace(0, 2'b01, 32'h0, 32'h0, 4, 32'h0, 32'h0, 32'h0, "static_fall");

    // reset mid-stretch aborts immediately
    run_trace(0, 2'b01, 32'h1, 32'h0, 4, 32'h0000_000C, 32'h0000_000C, 32'h0, "pre_rst");
    reset_n = 1'b0;
    #1;
    check_eq("mid_rst out", 32'(out_a), 32'd0);
    check_eq("mid_rst busy", 32'(busy_a), 32'd0);
    check_eq("mid_rst ovr", 32'(ovr_a), 32'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    run_trace(0, 2'b01, 32'h0, 32'h0, 10, 32'h0, 32'h0, 32'h0, "post_rst");
    run_trace(0, 2'b01, 32'h1, 32'h0, 12, 32'h0000_007C, 32'h0000_03FC, 32'h0, "rearm");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
